// File: rtl/raven_spi_pkg.sv
// raven_spi_pkg: shared constants, state encoding and frame builder for the housekeeping SPI master
package raven_spi_pkg;
  localparam logic [7:0] CMD_WRITE  = 8'h80;
  localparam logic [7:0] CMD_READ   = 8'h40;
  localparam int         FRAME_BITS = 24;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic rd, input logic [7:0] a, input logic [7:0] wd);
    return {rd ? CMD_READ : CMD_WRITE, a, rd ? 8'h00 : wd};
  endfunction
endpackage

// File: rtl/raven_spi_sckgen.sv
// raven_spi_sckgen: CLK_DIV-cycle phase timer with clear, strobing phase_end on the last cycle of each phase
module raven_spi_sckgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  output logic phase_end
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  logic [7:0] cnt_q, cnt_d;
  assign phase_end = (cnt_q == LAST);
  // reload on clear or at the end of every phase so each phase is exactly CLK_DIV cycles
  always_comb cnt_d = (clr || phase_end) ? 8'd0 : cnt_q + 8'd1;
  // phase counter register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/raven_spi_master.sv
// raven_spi_master: single-byte register read/write initiator for the raven_spi housekeeping slave
module raven_spi_master
  import raven_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       spi_csb,
  output logic       spi_sck,
  output logic       spi_sdi,
  input  logic       spi_sdo
);
  state_e                  state_q, state_d;
  logic                    sck_q, sck_d;
  logic                    csb_q, csb_d;
  logic                    rw_q, rw_d;
  logic                    done_q, done_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [7:0]              rx_q, rx_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [4:0]              bit_q, bit_d;
  logic                    phase_end;

  raven_spi_sckgen #(.CLK_DIV(CLK_DIV)) u_sckgen (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (state_q == IDLE),
    .phase_end (phase_end)
  );

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign spi_csb = csb_q;
  assign spi_sck = sck_q;
  // SDI is the TX MSB; the final shift at the last falling SCK empties the register, so SDI is 0 in HOLD and idle
  assign spi_sdi = tx_q[FRAME_BITS-1];

  // frame sequencing: next state, SCK/CSB levels, shift registers and read capture
  always_comb begin
    state_d = state_q;
    sck_d   = sck_q;
    csb_d   = csb_q;
    rw_d    = rw_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        csb_d   = 1'b0;
        rw_d    = rw;
        tx_d    = build_frame(rw, addr, wdata);
        bit_d   = 5'd0;
      end
      SETUP: if (phase_end) begin
        state_d = SHIFT;
        sck_d   = 1'b1;
      end
      SHIFT: if (phase_end) begin
        if (sck_q) begin
          sck_d = 1'b0;
          tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == 5'd23) state_d = HOLD;
          else bit_d = bit_q + 5'd1;
        end else begin
          sck_d = 1'b1;
          if (bit_q[4]) rx_d = {rx_q[6:0], spi_sdo};
        end
      end
      HOLD: if (phase_end) begin
        state_d = GAP;
        csb_d   = 1'b1;
        done_d  = 1'b1;
        rdata_d = rw_q ? rx_q : rdata_q;
      end
      GAP: if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any frame and clears rdata
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
      bit_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      sck_q   <= sck_d;
      csb_q   <= csb_d;
      rw_q    <= rw_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
    end
endmodule

// File: doc/raven_spi_master.md
# raven_spi_master

Housekeeping-SPI initiator: performs single-byte register reads and writes on the `raven_spi` housekeeping slave (SCK/SDI/CSB in, SDO out) from a simple start/done request port. It runs on one system clock, derives SCK by division, and drives the slave's pads (or the slave directly in bench/loopback builds). It is used for bring-up and by test logic that configures PLL trim, enables, and IDs over the housekeeping interface.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles; legal range 2..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `rw`  in  1  1=read, 0=write; captured on acceptance.
- `addr`  in  8  register address; captured on acceptance.
- `wdata`  in  8  write data; captured on acceptance (ignored for reads).
- `busy`  out  1  transfer or deselect gap in progress.
- `done`  out  1  one-cycle pulse at end of frame.
- `rdata`  out  8  read result; valid from the `done` cycle until the next read's `done`.
- `spi_csb`  out  1  chip select, active low.
- `spi_sck`  out  1  SPI clock, mode 0 (idle low).
- `spi_sdi`  out  1  master-to-slave data.
- `spi_sdo`  in  1  slave-to-master data.

## Operation
- Frame is 24 bits, MSB first: command byte, address byte, data byte. Commands: write = 8'h80, read = 8'h40.
- During a read, the master drives 8'h00 on SDI in the data byte and shifts in SDO.
- States:
  - IDLE → SETUP on accepted `start`.
  - SETUP: CSB low, SCK low, SDI = frame bit 23, held CLK_DIV cycles.
  - SHIFT: 24 high phases with 23 interleaved low phases, each CLK_DIV cycles. SDI updates to the next bit on each falling SCK. SDO is sampled in the cycle SCK goes high; only bits 7..0 (the data byte) are kept.
  - HOLD: SCK low, CLK_DIV cycles.
  - GAP: CSB high for CLK_DIV cycles, then IDLE.
- `rdata` updates at `done` for reads only; writes leave it unchanged.
- SDI returns to 0 in HOLD.
- `start` while `busy`=1 is ignored, with no queuing.
- `rw`, `addr` and `wdata` may change after acceptance without effect.
- Reset values: `spi_csb`=1, `spi_sck`=0, `spi_sdi`=0, `busy`=0, `done`=0, `rdata`=8'h00, state IDLE.
- Reset asserted mid-frame forces these values immediately (asynchronously) and abandons the frame. No `done` is issued, and `rdata` is cleared.
- Divider counter: 8 bits; it reloads at every phase boundary and at state entry.

## Timing
- `start` sampled high at edge t0 (with `busy`=0):
  - `busy`=1 and `spi_csb`=0 from t0+1.
  - First SCK rise at t0+1+CLK_DIV.
  - SCK rises at t0+1+CLK_DIV·(2k+1) for k=0..23.
- CSB rises and `done` pulses at t0+1+49·CLK_DIV; at CLK_DIV=4 this is t0+197.
- `busy` falls at t0+1+50·CLK_DIV, so the earliest next accepted `start` is at that edge.
- SDO sample edge is half an SCK period after the slave's falling-edge update. No synchronizer is required because SCK is derived from `clk`.

## Structure
- Shared package `raven_spi_pkg`:
  - `CMD_WRITE`=8'h80, `CMD_READ`=8'h40, `FRAME_BITS`=24.
  - State encoding: IDLE, SETUP, SHIFT, HOLD, GAP.
- One sub-module, `raven_spi_sckgen`: a CLK_DIV phase-tick counter with clear, producing a one-cycle `phase_end` strobe.
- Top level holds the FSM, the 24-bit TX shift register, the 8-bit RX shift register, and the bit counter (5 bits, 0..23).

## Test plan
- Write, CLK_DIV=4, `addr`=8'h08, `wdata`=8'hA5:
  - SDI bits on SCK rises = 0x80, 0x08, 0xA5.
  - CSB low for exactly 196 cycles.
  - `done` at t0+197, `busy` falls at t0+201, `rdata` unchanged.
- Read, `addr`=8'h01, with the `raven_spi` slave (or a model) returning 8'h0B:
  - SDI = 0x40, 0x01, 0x00.
  - `rdata`=8'h0B at `done`.
  - Repeat at CLK_DIV=2 with `done` at t0+99.
- `start` pulsed at t0+50 and again in the `done` cycle of a write: both ignored, exactly one frame on the bus; a `start` at the `busy`-fall edge is accepted.
- `resetn` dropped after the 10th SCK rise of a read:
  - Same cycle: CSB=1, SCK=0, SDI=0, `busy`=0, `rdata`=0; no `done`.
  - After release, a write of 8'h3C to 8'h12 completes correctly.
- Back-to-back read 8'h00 then read 8'h01, slave returning 8'hC3 and 8'h5A:
  - `rdata`=8'hC3, then 8'h5A.
  - CSB high ≥ CLK_DIV+1 cycles between frames.
